multi_pit: RTL and testbench

//  Parametrised multi-channel programmable interval timer; generalises the single hard-wired PIT.
//  NUM_CH independent down-counters of WIDTH bits, each one-shot or repeating, optionally prescaled.
//  Per-channel expiry pulses, sticky maskable pending bits, and one OR-reduced interrupt line.

---
 rtl/pit_pkg.sv | 7 +
 rtl/pit_channel.sv | 58 +++++
 rtl/multi_pit.sv | 63 ++++++
 tb/tb_multi_pit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pit_pkg.sv
// pit_pkg: shared mode encodings and minimum-parameter constants for multi_pit
package pit_pkg;
  typedef enum logic {PIT_ONESHOT = 1'b0, PIT_REPEAT = 1'b1} pit_mode_e;
  localparam int MIN_NUM_CH = 2;
  localparam int MIN_WIDTH = 2;
  localparam int MIN_PRESCALE_DIV = 2;
endpackage

// File: rtl/pit_channel.sv
// pit_channel: one down-counter with reload/mode registers, expiry pulse and sticky pending flag
module pit_channel
  import pit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] reload,
  input  logic             rep,
  input  logic             div_on,
  input  logic             enable,
  input  logic             presc_tick,
  input  logic             clr,
  output logic             expired,
  output logic             pending,
  output logic             active
);
  logic [WIDTH-1:0] reload_q, count_q, count_d;
  pit_mode_e mode_q;
  logic div_on_q, active_q, active_d, expired_q, pending_q, pending_d, ce, hit;
  assign ce  = active_q & (div_on_q ? presc_tick : 1'b1);
  assign hit = ce & (count_q == WIDTH'(1)) & ~wr;
  // next state: a write overrides a coincident expiry; a set overrides a coincident clear
  always_comb begin
    count_d   = wr ? reload
              : hit ? (mode_q == PIT_REPEAT ? reload_q : '0)
              : (ce && count_q > WIDTH'(1)) ? count_q - WIDTH'(1) : count_q;
    active_d  = wr ? (enable & |reload) : (hit && mode_q == PIT_ONESHOT) ? 1'b0 : active_q;
    pending_d = hit | (pending_q & ~clr);
  end
  // channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q  <= '0;
      count_q   <= '0;
      mode_q    <= PIT_ONESHOT;
      div_on_q  <= 1'b0;
      active_q  <= 1'b0;
      expired_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      if (wr) begin
        reload_q <= reload;
        mode_q   <= pit_mode_e'(rep);
        div_on_q <= div_on;
      end
      count_q   <= count_d;
      active_q  <= active_d;
      expired_q <= hit;
      pending_q <= pending_d;
    end
  end
  assign expired = expired_q;
  assign pending = pending_q;
  assign active  = active_q;
endmodule

// File: rtl/multi_pit.sv
// multi_pit: multi-channel interval timer; optional shared prescaler enabled by MULTI_PIT_PRESCALER_EN
module multi_pit
  import pit_pkg::*;
#(
  parameter  int NUM_CH       = 4,
  parameter  int WIDTH        = 16,
  parameter  int PRESCALE_DIV = 16,
  localparam int CH_W         = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_reload,
  input  logic              cfg_repeat,
  input  logic              cfg_div_on,
  input  logic              cfg_enable,
  input  logic [NUM_CH-1:0] irq_mask,
  input  logic [NUM_CH-1:0] irq_clear,
  output logic [NUM_CH-1:0] expired,
  output logic [NUM_CH-1:0] irq_pending,
  output logic [NUM_CH-1:0] active,
  output logic              irq
);
  if (NUM_CH < MIN_NUM_CH) $error("multi_pit: NUM_CH too small");
  if (WIDTH < MIN_WIDTH) $error("multi_pit: WIDTH too small");
  if (PRESCALE_DIV < MIN_PRESCALE_DIV) $error("multi_pit: PRESCALE_DIV too small");
  logic presc_tick, irq_q;
`ifdef MULTI_PIT_PRESCALER_EN
  localparam int PW = $clog2(PRESCALE_DIV);
  logic [PW-1:0] presc_q;
  assign presc_tick = presc_q == PW'(PRESCALE_DIV - 1);
  // free-running prescaler shared by every channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else presc_q <= presc_tick ? '0 : presc_q + PW'(1);
  end
`else
  assign presc_tick = 1'b1;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pit_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (cfg_we && cfg_ch == CH_W'(i)),
      .reload    (cfg_reload),
      .rep       (cfg_repeat),
      .div_on    (cfg_div_on),
      .enable    (cfg_enable),
      .presc_tick(presc_tick),
      .clr       (irq_clear[i]),
      .expired   (expired[i]),
      .pending   (irq_pending[i]),
      .active    (active[i])
    );
  end
  // interrupt line registered from masked pending flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else irq_q <= |(irq_pending & irq_mask);
  end
  assign irq = irq_q;
endmodule

// File: tb/tb_multi_pit.sv
// tb_multi_pit: directed self-checking bench for multi_pit (3 channels, so cfg_ch=3 is out of range)
module tb_multi_pit;
  logic clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, cfg_repeat = 1'b0, cfg_div_on = 1'b0, cfg_enable = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [15:0] cfg_reload = '0;
  logic [2:0] irq_mask = '0, irq_clear = '0, expired, irq_pending, active;
  logic irq;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  multi_pit #(.NUM_CH(3), .WIDTH(16), .PRESCALE_DIV(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_reload(cfg_reload),
    .cfg_repeat(cfg_repeat), .cfg_div_on(cfg_div_on), .cfg_enable(cfg_enable),
    .irq_mask(irq_mask), .irq_clear(irq_clear), .expired(expired),
    .irq_pending(irq_pending), .active(active), .irq(irq)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic cfg(input logic [1:0] ch, input logic [15:0] rl, input logic rp, input logic dv, input logic en);
    cfg_we = 1'b1; cfg_ch = ch; cfg_reload = rl; cfg_repeat = rp; cfg_div_on = dv; cfg_enable = en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask
  task automatic quiet(input int n, input string tag);
    logic [2:0] acc = '0;
    for (int k = 0; k < n; k++) begin
      step(1);
      acc |= expired;
    end
    check(tag, 32'(acc), 32'h0);
  endtask
  task automatic clear_all();
    irq_clear = 3'b111;
    step(1);
    irq_clear = 3'b000;
  endtask
  initial begin
    int n;
    int p;
    step(2);
    check("rst_expired", 32'(expired), 32'h0);
    check("rst_pending", 32'(irq_pending), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    step(1);
    cfg(2'd0, 16'd4, 1'b1, 1'b0, 1'b1);
    step(2);
    check("mid_active", 32'(active), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_active", 32'(active), 32'h0);
    step(3);
    rst_n = 1'b1;
    quiet(6, "post_rst_no_pulse");
    check("post_rst_active", 32'(active), 32'h0);
    irq_mask = 3'b001;
    cfg(2'd0, 16'd10, 1'b1, 1'b0, 1'b1);
    step(9);
    check("per_k9", 32'(expired), 32'h0);
    step(1);
    check("per_k10_exp", 32'(expired), 32'h1);
    check("per_k10_pend", 32'(irq_pending), 32'h1);
    check("per_k10_irq", 32'(irq), 32'h0);
    step(1);
    check("per_k11_exp", 32'(expired), 32'h0);
    check("per_k11_irq", 32'(irq), 32'h1);
    step(8);
    check("per_k19", 32'(expired), 32'h0);
    step(1);
    check("per_k20", 32'(expired), 32'h1);
    irq_clear = 3'b001;
    step(1);
    irq_clear = 3'b000;
    check("clr_pend", 32'(irq_pending), 32'h0);
    check("clr_irq_lag", 32'(irq), 32'h1);
    step(1);
    check("clr_irq", 32'(irq), 32'h0);
    cfg(2'd0, 16'd10, 1'b1, 1'b0, 1'b0);
    check("stop_active", 32'(active), 32'h0);
    cfg(2'd1, 16'd3, 1'b0, 1'b0, 1'b1);
    check("os_active", 32'(active), 32'h2);
    step(2);
    check("os_k2", 32'(expired), 32'h0);
    step(1);
    check("os_k3_exp", 32'(expired), 32'h2);
    check("os_k3_active", 32'(active), 32'h0);
    check("os_k3_pend", 32'(irq_pending), 32'h2);
    step(1);
    check("masked_irq", 32'(irq), 32'h0);
    quiet(6, "os_no_more");
    clear_all();
    check("os_cleared", 32'(irq_pending), 32'h0);
    cfg(2'd0, 16'd4, 1'b1, 1'b0, 1'b1);
    step(3);
    cfg(2'd0, 16'd5, 1'b1, 1'b0, 1'b1);
    check("col_wr_exp", 32'(expired), 32'h0);
    check("col_wr_pend", 32'(irq_pending), 32'h0);
    step(4);
    check("col_k4", 32'(expired), 32'h0);
    step(1);
    check("col_k5", 32'(expired), 32'h1);
    step(4);
    irq_clear = 3'b001;
    step(1);
    irq_clear = 3'b000;
    check("col_clr_exp", 32'(expired), 32'h1);
    check("col_clr_pend", 32'(irq_pending), 32'h1);
    cfg(2'd0, 16'd5, 1'b0, 1'b0, 1'b0);
    clear_all();
`ifdef MULTI_PIT_PRESCALER_EN
    p = 32;
`else
    p = 2;
`endif
    cfg(2'd2, 16'd2, 1'b1, 1'b1, 1'b1);
    n = 0;
    while (!expired[2] && n < 40) begin
      step(1);
      n++;
    end
    check("presc_found", 32'(expired[2]), 32'h1);
`ifndef MULTI_PIT_PRESCALER_EN
    check("presc_first", 32'(n), 32'd2);
`endif
    step(p - 1);
    check("presc_gap", 32'(expired), 32'h0);
    step(1);
    check("presc_period", 32'(expired), 32'h4);
    cfg(2'd2, 16'd2, 1'b1, 1'b1, 1'b0);
    clear_all();
    cfg(2'd0, 16'd0, 1'b1, 1'b0, 1'b1);
    check("zero_active", 32'(active), 32'h0);
    quiet(5, "zero_quiet");
    cfg(2'd3, 16'd2, 1'b1, 1'b0, 1'b1);
    check("badch_active", 32'(active), 32'h0);
    quiet(4, "badch_quiet");
    check("end_pend", 32'(irq_pending), 32'h0);
    check("end_irq", 32'(irq), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
